// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the pet's UART link.
//   SYNC_BYTE / FRAME_LEN  : status frame layout (sync byte + 8 payload bytes)
//   FLAG_SLEEP_BIT         : position of the sleep flag in the flags byte
//   IDX_*                  : order in which the stats are placed in the frame
//   frame_state_e          : frame-level control states (top)
//   tx_state_e             : per-byte serializer states (uart_tx_byte)
package tamagotchi_pkg;

  localparam int STAT_W    = 5;
  localparam int NUM_STATS = 6;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int FRAME_LEN      = 9;
  localparam int FLAG_SLEEP_BIT = 0;

  localparam int IDX_HUNGER    = 0;
  localparam int IDX_HAPPINESS = 1;
  localparam int IDX_HEALTH    = 2;
  localparam int IDX_HYGIENE   = 3;
  localparam int IDX_ENERGY    = 4;
  localparam int IDX_SOCIAL    = 5;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_SEND,
    FR_DONE
  } frame_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // Zero-extends a stat to a frame byte.
  function automatic logic [7:0] stat_byte(input logic [STAT_W-1:0] s);
    return {{(8 - STAT_W){1'b0}}, s};
  endfunction

endpackage

// File: rtl/stats_frame_tx_if.sv
// Bundle between the stats block and the status frame transmitter.
//   send          : frame request (master -> slave)
//   hunger..social: live 5-bit stats (master -> slave)
//   is_sleeping   : live sleep flag (master -> slave)
//   uart_tx       : serial line, idle high (slave -> master)
//   busy          : frame in flight (slave -> master)
//   frame_done    : one-cycle pulse at frame completion (slave -> master)
interface stats_frame_tx_if;

  logic                             send;
  logic [tamagotchi_pkg::STAT_W-1:0] hunger;
  logic [tamagotchi_pkg::STAT_W-1:0] happiness;
  logic [tamagotchi_pkg::STAT_W-1:0] health;
  logic [tamagotchi_pkg::STAT_W-1:0] hygiene;
  logic [tamagotchi_pkg::STAT_W-1:0] energy;
  logic [tamagotchi_pkg::STAT_W-1:0] social;
  logic                             is_sleeping;
  logic                             uart_tx;
  logic                             busy;
  logic                             frame_done;

  modport master (
    output send, hunger, happiness, health, hygiene, energy, social, is_sleeping,
    input  uart_tx, busy, frame_done
  );

  modport slave (
    input  send, hunger, happiness, health, hygiene, energy, social, is_sleeping,
    output uart_tx, busy, frame_done
  );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 serializer for a single byte, LSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load data and begin a byte; honoured while ready is high
//   data       : byte to send
//   tx         : serial line, driven straight from a flop, idle high
//   ready      : high when idle or in the last cycle of the stop bit, so a
//                new byte can follow the stop bit with no idle gap
module uart_tx_byte
  import tamagotchi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1042
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e  state;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic       bit_end;

  assign bit_end = (cnt == CNT_LAST);
  assign ready   = (state == TX_IDLE) || ((state == TX_STOP) && bit_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          if (start) begin
            shreg   <= data;
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= 1'b0;
            state   <= TX_START;
          end
        end
        TX_START: begin
          if (bit_end) begin
            cnt   <= '0;
            tx    <= shreg[0];
            state <= TX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= TX_STOP;
            end else begin
              // shreg[0] is the bit currently on the line; the next one is [1]
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (start) begin
              shreg   <= data;
              bit_idx <= '0;
              tx      <= 1'b0;
              state   <= TX_START;
            end else begin
              tx    <= 1'b1;
              state <= TX_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/stats_frame_tx.sv
// Status frame transmitter: on send, snapshots the six stats and the sleep
// flag and sends a 9-byte 8N1 frame (sync, 6 stats, flags, XOR checksum).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : stats_frame_tx_if.slave -- send request, live stats and
//                sleep flag in; uart_tx, busy, frame_done out (all registered)
module stats_frame_tx
  import tamagotchi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1042
) (
  input  logic            clk,
  input  logic            rst_n,
  stats_frame_tx_if.slave bus
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  frame_state_e      state;
  logic [STAT_W-1:0] snap [NUM_STATS];
  logic              snap_sleep;
  logic [3:0]        byte_idx;   // byte currently on the line
  logic              busy_q;
  logic              done_q;
  logic [7:0]        flags_byte;
  logic [7:0]        checksum;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_ready;
  logic              tx_line;
  logic              accept;

  // DONE counts as not busy, so a request there starts the next frame at once.
  assign accept = (state != FR_SEND) && bus.send;

  always_comb begin
    flags_byte                 = '0;
    flags_byte[FLAG_SLEEP_BIT] = snap_sleep;
  end

  // Sync byte is excluded from the checksum.
  always_comb begin
    checksum = flags_byte;
    for (int i = 0; i < NUM_STATS; i++) begin
      checksum = checksum ^ stat_byte(snap[i]);
    end
  end

  // The sync byte is constant, so it can be offered in the same cycle the
  // snapshot is taken; later bytes come from the snapshot registers.
  always_comb begin
    tx_data  = SYNC_BYTE;
    tx_start = accept;
    if (state == FR_SEND) begin
      tx_start = tx_ready && (byte_idx < LAST_IDX);
      if (byte_idx < 4'(NUM_STATS)) begin
        tx_data = stat_byte(snap[byte_idx[2:0]]);
      end else if (byte_idx == 4'(NUM_STATS)) begin
        tx_data = flags_byte;
      end else begin
        tx_data = checksum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FR_IDLE;
      byte_idx   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      snap_sleep <= 1'b0;
      for (int i = 0; i < NUM_STATS; i++) begin
        snap[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        FR_IDLE, FR_DONE: begin
          if (bus.send) begin
            snap[IDX_HUNGER]    <= bus.hunger;
            snap[IDX_HAPPINESS] <= bus.happiness;
            snap[IDX_HEALTH]    <= bus.health;
            snap[IDX_HYGIENE]   <= bus.hygiene;
            snap[IDX_ENERGY]    <= bus.energy;
            snap[IDX_SOCIAL]    <= bus.social;
            snap_sleep          <= bus.is_sleeping;
            byte_idx            <= '0;
            busy_q              <= 1'b1;
            state               <= FR_SEND;
          end else begin
            busy_q <= 1'b0;
            state  <= FR_IDLE;
          end
        end
        FR_SEND: begin
          if (tx_ready) begin
            if (byte_idx < LAST_IDX) begin
              byte_idx <= byte_idx + 4'd1;
            end else begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= FR_DONE;
            end
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= FR_IDLE;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (tx_start),
    .data  (tx_data),
    .tx    (tx_line),
    .ready (tx_ready)
  );

  assign bus.uart_tx    = tx_line;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_stats_frame_tx.sv
module tb_stats_frame_tx;

  localparam int C  = 4;
  localparam int FL = 90 * C;
  localparam int HN = 8192;

  typedef logic [7:0] frame_t [9];

  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic [2:0] hist [HN];   // {uart_tx, busy, frame_done} per cycle

  stats_frame_tx_if bus ();

  stats_frame_tx #(.CLKS_PER_BIT(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cyc < HN) hist[cyc] <= {bus.uart_tx, bus.busy, bus.frame_done};

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step(1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_stats(input logic [4:0] s [6], input logic sl);
    bus.hunger      = s[0];
    bus.happiness   = s[1];
    bus.health      = s[2];
    bus.hygiene     = s[3];
    bus.energy      = s[4];
    bus.social      = s[5];
    bus.is_sleeping = sl;
  endtask

  task automatic rand_stats(output logic [4:0] s [6], output logic sl);
    for (int i = 0; i < 6; i++) s[i] = 5'($urandom_range(31, 0));
    sl = 1'($urandom_range(1, 0));
  endtask

  // Reference frame straight from the frame layout rules.
  function automatic frame_t model_frame(input logic [4:0] s [6], input logic sl);
    frame_t f;
    f[0] = 8'hA5;
    for (int i = 0; i < 6; i++) f[i + 1] = {3'b000, s[i]};
    f[7] = sl ? 8'h01 : 8'h00;
    f[8] = 8'h00;
    for (int i = 1; i <= 7; i++) f[8] = f[8] ^ f[i];
    return f;
  endfunction

  function automatic int count_fd(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (hist[i][0] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_not_idle(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (hist[i] !== 3'b100) n++;
    return n;
  endfunction

  // Pulses send for one edge; e is the edge that samples it.
  task automatic fire(output int e);
    bus.send = 1'b1;
    e = cyc + 1;
    step(1);
    bus.send = 1'b0;
  endtask

  // Decodes the frame whose start bit begins at sample e; needs cyc > e+FL.
  task automatic check_frame(input int e, input frame_t exp, input string tag);
    logic [7:0] got;
    logic       b;
    bit         framing;
    int         base;
    framing = 1'b1;
    for (int k = 0; k < 9; k++) begin
      got = '0;
      for (int j = 0; j < 10; j++) begin
        base = e + (10 * k + j) * C;
        b = hist[base][2];
        for (int t = 1; t < C; t++) if (hist[base + t][2] !== b) framing = 1'b0;
        if (j == 0 && b !== 1'b0) framing = 1'b0;
        if (j == 9 && b !== 1'b1) framing = 1'b0;
        if (j >= 1 && j <= 8) got[j - 1] = b;
      end
      chk($sformatf("%s_byte%0d", tag, k), 32'(got), 32'(exp[k]));
    end
    chk({tag, "_framing"}, 32'(framing), 32'd1);
    // {fd before end, fd at end, busy at end, tx at end, busy at start}
    chk({tag, "_timing"},
        32'({hist[e + FL - 1][0], hist[e + FL][0], hist[e + FL][1], hist[e + FL][2], hist[e][1]}),
        32'(5'b01011));
  endtask

  initial begin
    logic [4:0] sa [6];
    logic [4:0] sb [6];
    logic [4:0] sc [6];
    logic [4:0] sz [6];
    logic       la, lb, lc;
    frame_t     lit;
    int         e, e1, r0;

    rst_n    = 1'b0;
    bus.send = 1'b0;
    for (int i = 0; i < 6; i++) sz[i] = 5'd0;
    drive_stats(sz, 1'b0);

    // Reset values
    step(3);
    chk("rst_uart_tx", 32'(bus.uart_tx), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    rst_n = 1'b1;
    r0 = cyc;
    step(1000);
    chk("idle_1000", 32'(count_not_idle(r0, cyc - 1)), 32'd0);

    // Directed single frame
    sa = '{5'd31, 5'd16, 5'd1, 5'd10, 5'd21, 5'd0};
    drive_stats(sa, 1'b1);
    step(2);
    fire(e);
    step_to(e + FL + 6);
    lit = '{8'hA5, 8'h1F, 8'h10, 8'h01, 8'h0A, 8'h15, 8'h00, 8'h01, 8'h10};
    check_frame(e, lit, "single");
    chk("single_fd_count", 32'(count_fd(e, e + FL + 5)), 32'd1);

    // Send while busy is ignored; stats change after the snapshot
    rand_stats(sa, la);
    drive_stats(sa, la);
    step(3);
    fire(e);
    step_to(e + 99);
    bus.send = 1'b1;
    drive_stats(sz, 1'b0);
    step(1);
    bus.send = 1'b0;
    step_to(e + FL + 21);
    check_frame(e, model_frame(sa, la), "ignore");
    chk("ignore_fd_count", 32'(count_fd(e, e + FL + 20)), 32'd1);
    chk("ignore_idle_after", 32'(count_not_idle(e + FL + 1, e + FL + 20)), 32'd0);

    // Back-to-back with send held high; each frame snapshots fresh values
    rand_stats(sa, la);
    rand_stats(sb, lb);
    rand_stats(sc, lc);
    drive_stats(sa, la);
    step(2);
    bus.send = 1'b1;
    e1 = cyc + 1;
    step(50);
    drive_stats(sb, lb);
    step_to(e1 + 361 + 50);
    drive_stats(sc, lc);
    step_to(e1 + 722);
    bus.send = 1'b0;
    drive_stats(sz, 1'b0);
    step_to(e1 + 1082 + 11);
    check_frame(e1, model_frame(sa, la), "b2b0");
    check_frame(e1 + 361, model_frame(sb, lb), "b2b1");
    check_frame(e1 + 722, model_frame(sc, lc), "b2b2");
    chk("b2b_fd_count", 32'(count_fd(e1, e1 + 1092)), 32'd3);

    // Reset during the second data bit of the sync byte (a 0 on the line)
    rand_stats(sa, la);
    drive_stats(sa, la);
    step(2);
    fire(e);
    step_to(e + 2 * C + 1);
    @(negedge clk);
    chk("midrst_line_before", 32'(bus.uart_tx), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_line_async", 32'(bus.uart_tx), 32'd1);
    chk("midrst_busy_async", 32'(bus.busy), 32'd0);
    step(3);
    rst_n = 1'b1;
    r0 = cyc;
    step(400);
    chk("midrst_no_fd", 32'(count_fd(e, cyc - 1)), 32'd0);
    chk("midrst_idle_after", 32'(count_not_idle(r0, cyc - 1)), 32'd0);
    rand_stats(sb, lb);
    drive_stats(sb, lb);
    step(1);
    fire(e);
    step_to(e + FL + 6);
    check_frame(e, model_frame(sb, lb), "post_rst");

    // Checksum corner: everything zero
    drive_stats(sz, 1'b0);
    step(2);
    fire(e);
    step_to(e + FL + 6);
    lit = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_frame(e, lit, "zeros");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/stats_frame_tx.md
# stats_frame_tx

Serial status transmitter for the pet: on a `send` request it snapshots the six 5-bit stats and the sleep flag, then shifts them out `uart_tx` as one 9-byte 8N1 frame, LSB first. It is the outbound half of the UART link. The existing receiver turns host bytes into commands; this block turns pet state into host-bound bytes. It sits beside the stats block and is typically triggered by the one-second tick.

## Interface
- `CLKS_PER_BIT`, default 1042: clock cycles per UART bit (10 MHz / 9600 baud); must be ≥ 2.
- `clk  in  1` — system clock.
- `rst_n  in  1` — reset; one clock; reset is asynchronous and active-low.
- `send  in  1` — frame request; sampled every cycle.
- `hunger, happiness, health, hygiene, energy, social  in  5 each` — live stat values.
- `is_sleeping  in  1` — live sleep flag.
- `uart_tx  out  1` — serial line; idle high.
- `busy  out  1` — high while a frame is in flight.
- `frame_done  out  1` — one-cycle pulse when a frame completes.

## Operation
- Frame bytes, in order:
  - B0 = 0xA5 (sync).
  - B1..B6 = {3'b000, stat}, in the order hunger, happiness, health, hygiene, energy, social.
  - B7 = flags: bit0 = is_sleeping, bits7:1 = 0.
  - B8 = checksum = B1 ^ B2 ^ … ^ B7; B0 is excluded.
- Each byte is sent as: start bit (0), 8 data bits LSB first, stop bit (1). There is no gap between bytes.
- FSM states: IDLE → START → DATA → STOP → (next byte: START | last byte: DONE) → IDLE.
  - IDLE: `uart_tx`=1, `busy`=0.
  - IDLE with `send`=1: capture the snapshot of all stats and the flag, clear the byte index to 0, preload the checksum to 0, go to START.
  - START / DATA / STOP: each bit lasts exactly CLKS_PER_BIT cycles, counted by a baud counter that reloads on every bit.
  - DATA advances a 3-bit bit index 0→7.
  - STOP: at the end of the last stop-bit cycle, if byte index < 8, increment the index and go to START. Otherwise go to DONE.
  - DONE: lasts one cycle; `frame_done`=1 and `busy`=0; then IDLE.
- The checksum accumulates B1..B7 from the snapshot. It is combinational from the snapshot or accumulated at byte load; either is acceptable as long as B8 is correct.
- `send` while `busy`=1 is ignored. It is not queued.
- `send` in the DONE cycle is accepted, because `busy` is 0 then; the next frame starts directly.
- Stat inputs changing mid-frame have no effect; only the snapshot is transmitted.

## Timing
- Reset values: `uart_tx`=1, `busy`=0, `frame_done`=0; FSM in IDLE; counters 0; snapshot 0.
- Reset asserted mid-frame: `uart_tx` returns to 1 asynchronously and the frame is abandoned. No `frame_done` is produced.
- `send` sampled high at edge N:
  - From edge N: `busy`=1 and `uart_tx`=0 (start bit of B0).
  - From edge N + 90·CLKS_PER_BIT: `frame_done`=1 for exactly one cycle, and `busy`=0.
- All outputs are registered. `uart_tx` is driven directly from a flop and must not glitch.
- The baud counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 with no wrap error at the maximum value.

## Structure
- Shared package `tamagotchi_pkg` holds:
  - `SYNC_BYTE` = 8'hA5
  - `FRAME_LEN` = 9
  - `FLAG_SLEEP_BIT` = 0
  - the stat byte order as localparam indices
- Sub-module `uart_tx_byte` (parameter CLKS_PER_BIT):
  - Ports: `clk`, `rst_n`, `start`, `data[7:0]`, `tx`, `ready`.
  - Owns the baud counter and the START/DATA/STOP sequencing for one byte.
- The top of this block owns the snapshot registers, the byte index, the checksum, the byte mux, and the IDLE/DONE control.

## Test plan
All scenarios use CLKS_PER_BIT=4, so one frame is 360 cycles.
- Reset: hold `rst_n`=0 → `uart_tx`=1, `busy`=0, `frame_done`=0; release with no `send` → line stays 1 for 1000 cycles.
- Single frame: hunger=31, happiness=16, health=1, hygiene=10, energy=21, social=0, is_sleeping=1; pulse `send` → decoded bytes A5 1F 10 01 0A 15 00 01 10. Start bit is 0 and stop bit is 1 on every byte; `frame_done` pulses exactly 360 cycles after `send`.
- Ignore while busy, plus snapshot: pulse `send` at cycle 100 of a frame and change every stat to 0 → exactly one frame is sent, it carries the original values, and there is a single `frame_done`.
- Back-to-back: hold `send`=1 continuously → consecutive frames with `frame_done` every 361 cycles. The line never idles except during the DONE cycle, where `uart_tx`=1.
- Reset mid-frame: assert `rst_n`=0 during a data bit holding 0 → `uart_tx` goes to 1 without waiting for a clock edge. After release, `busy`=0 and there is no `frame_done`; a new `send` produces a complete, correct frame.
- Checksum corner: all stats 0 and is_sleeping=0 → bytes A5 00 00 00 00 00 00 00 00.
